// File: rtl/adc_volt_pkg.sv
// Shared types and widths for the voltmeter ADC front end.
package adc_volt_pkg;

    typedef enum logic [2:0] {
        CAL,
        MID,
        DIVP,
        DIVN,
        MEAS
    } state_e;

    localparam int FRAC  = 16;
    localparam int DIV_W = 29;
    localparam int MV_W  = 13;

    // Keeps both divisors (255-mid and mid) non-zero.
    function automatic logic [7:0] clamp_mid(input logic [7:0] m);
        if (m == 8'd0)   return 8'd1;
        if (m == 8'd255) return 8'd254;
        return m;
    endfunction

endpackage

// File: rtl/adc_volt_if.sv
// Voltage result bundle from the ADC front end to the display stage.
interface adc_volt_if;
    import adc_volt_pkg::*;

    logic [MV_W-1:0] volt_mv;
    logic            volt_neg;
    logic            volt_valid;

    modport master (
        output volt_mv,
        output volt_neg,
        output volt_valid
    );

    modport slave (
        input volt_mv,
        input volt_neg,
        input volt_valid
    );

endinterface

// File: rtl/serial_div.sv
// Restoring serial divider: one load cycle, then one quotient bit per cycle.
module serial_div import adc_volt_pkg::*; #(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  quo_q;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic [W:0]    shifted;
    logic          ge;
    logic [W-1:0]  rem_sub;

    // Remainder stays below the divisor, so a W-bit subtract is exact.
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        ge      = shifted >= {1'b0, dvs_q};
        rem_sub = shifted[W-1:0] - dvs_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                quo_q <= dividend;
                rem_q <= '0;
                dvs_q <= divisor;
                cnt_q <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                rem_q <= ge ? rem_sub : shifted[W-1:0];
                quo_q <= {quo_q[W-2:0], ge};
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(W-1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/adc_volt_conv.sv
// ADC front end: ad_clk generation, zero calibration and
// conversion of averaged codes to signed millivolts.
module adc_volt_conv import adc_volt_pkg::*; #(
    parameter int CLK_DIV  = 4,
    parameter int CAL_LOG2 = 10,
    parameter int AVG_LOG2 = 4,
    parameter int VREF_MV  = 5000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] ad_data,
    output logic       ad_clk,
    output logic       cal_done,
    adc_volt_if.master vout
);

    localparam int DCW   = $clog2(CLK_DIV);
    localparam int ACC_W = 8 + CAL_LOG2;
    localparam int PW    = 8 + DIV_W;
    localparam int MW    = PW - FRAC;
    localparam logic [DIV_W-1:0] DIVIDEND =
        DIV_W'(VREF_MV * (2 ** FRAC));
    localparam logic [MV_W-1:0] MV_MAX = MV_W'(VREF_MV);

    state_e state_q, state_d;

    logic [DCW-1:0]      div_cnt;
    logic                smp;
    logic                take;
    logic                take_q;
    logic [7:0]          d_q;
    logic [CAL_LOG2-1:0] cnt_q;
    logic [ACC_W-1:0]    acc_q;
    logic                first;
    logic                last_cal;
    logic                last_win;
    logic                win_q;
    logic                avg_vld_q;
    logic [7:0]          avg_q;
    logic [7:0]          mid_q;
    logic [7:0]          mid_calc;
    logic [DIV_W-1:0]    step_p_q;
    logic [DIV_W-1:0]    step_n_q;

    logic             div_start;
    logic [DIV_W-1:0] div_dvs;
    logic             div_busy;
    logic             div_done;
    logic [DIV_W-1:0] div_q;

    logic             pos;
    logic [7:0]       diff;
    logic [DIV_W-1:0] step;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    rnd;
    logic [MW-1:0]    mv_full;
    logic [MV_W-1:0]  mv_sat;

    assign smp  = (div_cnt == '0);
    assign take = smp && (state_q == CAL || state_q == MEAS);

    assign last_cal = &cnt_q;
    assign last_win = &cnt_q[AVG_LOG2-1:0];
    assign first    = (state_q == CAL) ? (cnt_q == '0)
                    : (cnt_q[AVG_LOG2-1:0] == '0);
    assign mid_calc = clamp_mid(acc_q[CAL_LOG2 +: 8]);
    assign cal_done = (state_q == MEAS);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt <= '0;
            ad_clk  <= 1'b0;
            d_q     <= '0;
            take_q  <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DCW'(CLK_DIV-1))
                     ? '0 : div_cnt + DCW'(1);
            ad_clk  <= div_cnt >= DCW'(CLK_DIV/2);
            take_q  <= take;
            if (smp) d_q <= ad_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= CAL;
        else         state_q <= state_d;
    end

    // One divider serves both steps; DIVN is launched off DIVP's done.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        div_dvs   = '0;
        unique case (state_q)
            CAL: begin
                if (take_q && last_cal) state_d = MID;
            end
            MID: begin
                div_start = !div_busy;
                div_dvs   = DIV_W'(8'd255 - mid_calc);
                if (!div_busy) state_d = DIVP;
            end
            DIVP: begin
                if (div_done) begin
                    div_start = 1'b1;
                    div_dvs   = DIV_W'(mid_q);
                    state_d   = DIVN;
                end
            end
            DIVN: begin
                if (div_done) state_d = MEAS;
            end
            MEAS: begin
                state_d = MEAS;
            end
            default: state_d = CAL;
        endcase
    end

    serial_div #(.W(DIV_W)) u_div (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (div_dvs),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            win_q     <= 1'b0;
            avg_vld_q <= 1'b0;
            avg_q     <= '0;
            mid_q     <= '0;
            step_p_q  <= '0;
            step_n_q  <= '0;
        end else begin
            win_q     <= take_q && (state_q == MEAS) && last_win;
            avg_vld_q <= win_q;
            if (take_q) begin
                acc_q <= (first ? '0 : acc_q) + ACC_W'(d_q);
                cnt_q <= cnt_q + CAL_LOG2'(1);
            end
            if (win_q) avg_q <= acc_q[AVG_LOG2 +: 8];
            if (state_q == MID) mid_q <= mid_calc;
            if (state_q == DIVP && div_done) step_p_q <= div_q;
            if (state_q == DIVN && div_done) step_n_q <= div_q;
        end
    end

    always_comb begin
        pos     = avg_q >= mid_q;
        diff    = pos ? avg_q - mid_q : mid_q - avg_q;
        step    = pos ? step_p_q : step_n_q;
        prod    = PW'(diff) * PW'(step);
        rnd     = prod + PW'(2 ** (FRAC-1));
        mv_full = MW'(rnd >> FRAC);
        mv_sat  = (mv_full > MW'(VREF_MV))
                ? MV_MAX : mv_full[MV_W-1:0];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vout.volt_mv    <= '0;
            vout.volt_neg   <= 1'b0;
            vout.volt_valid <= 1'b0;
        end else begin
            vout.volt_valid <= avg_vld_q;
            if (avg_vld_q) begin
                vout.volt_mv  <= mv_sat;
                vout.volt_neg <= !pos && (mv_sat != '0);
            end
        end
    end

endmodule
